ma_threshold_detect: RTL and testbench
======================================

# ma_threshold_detect

Hysteresis threshold detector that sits directly downstream of the moving-average filter and consumes its 32-bit averaged output. It turns the smoothed sample stream into a debounced binary level, single-cycle rise/fall event pulses and a saturating count of rising events. Control logic and event logging in the design read these outputs instead of raw filter data.

## Interface
- CONFIRM, 4: consecutive qualifying valid samples required to change level; legal range 1..255.
- CNT_WIDTH, 16: width of the rising-event counter.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- in_valid  in  1  din holds a new filter sample this cycle.
- din  in  32  unsigned averaged sample from the moving-average stage.
- thr_hi  in  32  unsigned upper threshold.
- thr_lo  in  32  unsigned lower threshold.
- cnt_clr  in  1  synchronous clear of event_count.
- level  out  1  debounced detector state: 1 = high, 0 = low.
- rise_pulse  out  1  one-cycle pulse when level goes 0->1.
- fall_pulse  out  1  one-cycle pulse when level goes 1->0.
- event_count  out  CNT_WIDTH  saturating count of rising events.
- cfg_err  out  1  registered flag, 1 while thr_lo > thr_hi.

## Operation
- States: LOW, ARM_HI, HIGH, ARM_LO. level = 1 in HIGH and ARM_LO, 0 otherwise.
- Qualifiers, evaluated only when in_valid = 1:
  - hi_q = din > thr_hi (strict).
  - lo_q = din < thr_lo (strict).
  - Equality never qualifies.
- When in_valid = 0, the state, the confirm counter and all outputs hold. Pulses still deassert.
- Confirm counter: 8 bits. Cleared on every state change and on every disqualifying valid sample.
- LOW:
  - If hi_q and CONFIRM = 1, go to HIGH.
  - Else if hi_q, go to ARM_HI with count = 1.
  - Otherwise stay in LOW.
- ARM_HI:
  - If hi_q and count + 1 = CONFIRM, go to HIGH.
  - If hi_q otherwise, increment count.
  - If not hi_q, return to LOW.
- HIGH and ARM_LO: mirror of the above using lo_q, ending in LOW.
- Entering HIGH: rise_pulse = 1 for one cycle, and event_count increments, saturating at all-ones.
- Entering LOW from ARM_LO (or directly from HIGH when CONFIRM = 1): fall_pulse = 1 for one cycle.
- cnt_clr: event_count is set to 0. If a rising transition happens in the same cycle, event_count is set to 1.
- cfg_err:
  - Registered each cycle from thr_lo > thr_hi.
  - While cfg_err = 1, valid samples are ignored: state, counter and level hold, and no pulses are produced.
  - Normal evaluation resumes on the first valid sample after cfg_err clears.
- Thresholds may change at any time. They take effect on the next valid sample. A partial confirm run is not cleared by a threshold change alone.

## Timing
- Reset (rst_n = 0 at a clock edge) sets: state = LOW, count = 0, level = 0, rise_pulse = 0, fall_pulse = 0, event_count = 0, cfg_err = 0.
- Reset mid-ARM discards the partial run. Reset dominates cnt_clr and all sample inputs.
- Latency: all outputs are registered.
  - The edge that accepts the CONFIRM-th consecutive qualifying sample updates level, the pulse and event_count together.
  - These are visible in the following cycle. There is no combinational path from din to any output.
- Pulses are exactly one cycle wide, even when the next cycle has in_valid = 0.
- rise_pulse and fall_pulse are never asserted together.
- Minimum spacing between opposite pulses is CONFIRM valid samples.
- Input is accepted every cycle; there is no backpressure to the filter.

## Test plan
- Reset, then stream: CONFIRM = 4, thr_hi = 100, thr_lo = 50, din = 120 valid for 4 cycles.
  - Required: level rises after the 4th sample edge, rise_pulse is high for one cycle, event_count = 1.
  - A 3-sample run followed by din = 80 leaves level = 0.
- Hysteresis/equality: from HIGH, din = 50 for 10 samples, then 49 for 4 samples.
  - Required: level stays 1 through the 50s, then fall_pulse fires after the 4th 49.
- Valid gaps: the 4 qualifying samples are interleaved with in_valid = 0 cycles.
  - Required: the transition occurs on the 4th valid sample, and the gaps neither reset nor advance the counter.
- Saturation/clear: CNT_WIDTH = 4, 20 rise/fall cycles.
  - Required: event_count holds at 15.
  - cnt_clr together with a rise gives 1; cnt_clr alone gives 0.
- cfg_err: set thr_lo = 200 and thr_hi = 100 while in ARM_HI.
  - Required: cfg_err = 1 next cycle, samples ignored, state frozen.
  - Restore thr_lo = 50: the run continues from the held count.
- Reset mid-operation: assert rst_n = 0 for one cycle in ARM_LO while level = 1.
  - Required: level = 0, no fall_pulse, event_count = 0.

Source files
------------

// File: rtl/ma_threshold_detect.sv
// Hysteresis threshold detector on the moving-average output: debounced level, rise/fall pulses, saturating rise count.
// Latency: all outputs are registered, one cycle after the accepting edge; no backpressure, a sample is accepted every cycle.
module ma_threshold_detect #(
  parameter int unsigned CONFIRM   = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [31:0]          din,
  input  logic [31:0]          thr_hi,
  input  logic [31:0]          thr_lo,
  input  logic                 cnt_clr,
  output logic                 level,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
  output logic [CNT_WIDTH-1:0] event_count,
  output logic                 cfg_err
);

  typedef enum logic [1:0] {S_LOW, S_ARM_HI, S_HIGH, S_ARM_LO} state_t;

  localparam logic [8:0]           CONFIRM_W   = 9'(CONFIRM);
  localparam bit                   CONFIRM_ONE = (CONFIRM == 1);
  localparam logic [CNT_WIDTH-1:0] EVT_ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] EVT_MAX     = '1;

  state_t               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 level_q, level_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;
  logic [CNT_WIDTH-1:0] evt_q, evt_d;
  logic                 cfg_err_q, cfg_err_d;

  logic       eval;
  logic       hi_qual;
  logic       lo_qual;
  logic [8:0] cnt_inc;
  logic       run_done;

  // A misordered threshold pair freezes evaluation from the cycle after it is seen.
  assign eval     = in_valid && !cfg_err_q;
  assign hi_qual  = din > thr_hi;
  assign lo_qual  = din < thr_lo;
  assign cnt_inc  = {1'b0, cnt_q} + 9'd1;
  assign run_done = (cnt_inc == CONFIRM_W);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    cfg_err_d = thr_lo > thr_hi;
    if (eval) begin
      case (state_q)
        S_LOW: begin
          cnt_d = 8'd0;
          if (hi_qual) begin
            if (CONFIRM_ONE) begin
              state_d = S_HIGH;
              rise_d  = 1'b1;
            end else begin
              state_d = S_ARM_HI;
              cnt_d   = 8'd1;
            end
          end
        end
        S_ARM_HI: begin
          if (hi_qual && run_done) begin
            state_d = S_HIGH;
            cnt_d   = 8'd0;
            rise_d  = 1'b1;
          end else if (hi_qual) begin
            cnt_d = cnt_inc[7:0];
          end else begin
            state_d = S_LOW;
            cnt_d   = 8'd0;
          end
        end
        S_HIGH: begin
          cnt_d = 8'd0;
          if (lo_qual) begin
            if (CONFIRM_ONE) begin
              state_d = S_LOW;
              fall_d  = 1'b1;
            end else begin
              state_d = S_ARM_LO;
              cnt_d   = 8'd1;
            end
          end
        end
        default: begin
          if (lo_qual && run_done) begin
            state_d = S_LOW;
            cnt_d   = 8'd0;
            fall_d  = 1'b1;
          end else if (lo_qual) begin
            cnt_d = cnt_inc[7:0];
          end else begin
            state_d = S_HIGH;
            cnt_d   = 8'd0;
          end
        end
      endcase
    end

    level_d = (state_d == S_HIGH) || (state_d == S_ARM_LO);

    // Clear wins over accumulated history, but a rise in the same cycle still counts.
    evt_d = evt_q;
    if (cnt_clr) begin
      evt_d = rise_d ? EVT_ONE : '0;
    end else if (rise_d && (evt_q != EVT_MAX)) begin
      evt_d = evt_q + EVT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_LOW;
      cnt_q     <= 8'd0;
      level_q   <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      evt_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      evt_q     <= evt_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign level       = level_q;
  assign rise_pulse  = rise_q;
  assign fall_pulse  = fall_q;
  assign event_count = evt_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_ma_threshold_detect.sv
// Vector table bench for ma_threshold_detect (CONFIRM=4, CNT_WIDTH=4); expected outputs queued at drive time.
// Latency: each vector is checked one edge after it is driven.
// Backpressure: none; the DUT accepts a sample every cycle.
module tb_ma_threshold_detect;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] din = '0;
    logic [31:0] thr_hi = 32'd100;
    logic [31:0] thr_lo = 32'd50;
    logic        cnt_clr = 1'b0;
    logic        level, rise_pulse, fall_pulse, cfg_err;
    logic [3:0]  event_count;

    ma_threshold_detect #(.CONFIRM(4), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .din(din),
        .thr_hi(thr_hi), .thr_lo(thr_lo), .cnt_clr(cnt_clr),
        .level(level), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .event_count(event_count), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // exp packs {cfg_err, level, rise_pulse, fall_pulse, event_count[3:0]}
    typedef struct {
        logic        rst_n;
        logic        vld;
        logic [31:0] din;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        clr;
        logic [7:0]  exp;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] exp_q[$];
    int         errors = 0;
    int         checks = 0;
    bit         done = 1'b0;

    function automatic void add(input logic r, input logic v, input logic [31:0] d,
                                input logic [31:0] h, input logic [31:0] l, input logic c,
                                input logic ce, input logic lv, input logic ri,
                                input logic fa, input logic [3:0] ev);
        vec_t t;
        t.rst_n = r; t.vld = v; t.din = d; t.hi = h; t.lo = l; t.clr = c;
        t.exp = {ce, lv, ri, fa, ev};
        tbl.push_back(t);
    endfunction

    function automatic void sam(input logic [31:0] d, input logic lv, input logic ri,
                                input logic fa, input logic [3:0] ev);
        add(1'b1, 1'b1, d, 32'd100, 32'd50, 1'b0, 1'b0, lv, ri, fa, ev);
    endfunction

    function automatic void idle(input logic lv, input logic [3:0] ev);
        add(1'b1, 1'b0, 32'd0, 32'd100, 32'd50, 1'b0, 1'b0, lv, 1'b0, 1'b0, ev);
    endfunction

    initial begin
        #200000;
        if (!done) begin
            errors++;
            $display("FAIL timeout: vector table did not complete");
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        logic [7:0] got, e;
        int ev;
        // Reset
        add(1'b0, 1'b0, 32'd0, 32'd100, 32'd50, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        add(1'b0, 1'b1, 32'd120, 32'd100, 32'd50, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        // Equality with thr_hi never qualifies
        for (int i = 0; i < 5; i++) sam(32'd100, 1'b0, 1'b0, 1'b0, 4'd0);
        // 3-sample run broken by 80
        for (int i = 0; i < 3; i++) sam(32'd120, 1'b0, 1'b0, 1'b0, 4'd0);
        sam(32'd80, 1'b0, 1'b0, 1'b0, 4'd0);
        // Full run of 4 rises on the 4th sample
        for (int i = 0; i < 3; i++) sam(32'd120, 1'b0, 1'b0, 1'b0, 4'd0);
        sam(32'd120, 1'b1, 1'b1, 1'b0, 4'd1);
        idle(1'b1, 4'd1);
        // Hysteresis: 50 holds, 49 x4 falls
        for (int i = 0; i < 10; i++) sam(32'd50, 1'b1, 1'b0, 1'b0, 4'd1);
        for (int i = 0; i < 3; i++) sam(32'd49, 1'b1, 1'b0, 1'b0, 4'd1);
        sam(32'd49, 1'b0, 1'b0, 1'b1, 4'd1);
        // Qualifying samples interleaved with gaps
        sam(32'd120, 1'b0, 1'b0, 1'b0, 4'd1); idle(1'b0, 4'd1);
        sam(32'd120, 1'b0, 1'b0, 1'b0, 4'd1); idle(1'b0, 4'd1);
        sam(32'd120, 1'b0, 1'b0, 1'b0, 4'd1); idle(1'b0, 4'd1); idle(1'b0, 4'd1);
        sam(32'd120, 1'b1, 1'b1, 1'b0, 4'd2);
        idle(1'b1, 4'd2);
        // Back to LOW, then park in ARM_HI with count 2
        for (int i = 0; i < 3; i++) sam(32'd10, 1'b1, 1'b0, 1'b0, 4'd2);
        sam(32'd10, 1'b0, 1'b0, 1'b1, 4'd2);
        sam(32'd120, 1'b0, 1'b0, 1'b0, 4'd2);
        sam(32'd120, 1'b0, 1'b0, 1'b0, 4'd2);
        // Misordered thresholds freeze evaluation
        add(1'b1, 1'b0, 32'd0, 32'd100, 32'd200, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
        add(1'b1, 1'b1, 32'd120, 32'd100, 32'd200, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
        add(1'b1, 1'b1, 32'd120, 32'd100, 32'd200, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
        add(1'b1, 1'b1, 32'd10, 32'd100, 32'd200, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
        add(1'b1, 1'b1, 32'd120, 32'd100, 32'd200, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
        idle(1'b0, 4'd2);
        // Resume from held count 2: two more samples complete the run
        sam(32'd120, 1'b0, 1'b0, 1'b0, 4'd2);
        sam(32'd120, 1'b1, 1'b1, 1'b0, 4'd3);
        // Reset while in ARM_LO with level high
        sam(32'd10, 1'b1, 1'b0, 1'b0, 4'd3);
        sam(32'd10, 1'b1, 1'b0, 1'b0, 4'd3);
        add(1'b0, 1'b1, 32'd10, 32'd100, 32'd50, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        sam(32'd10, 1'b0, 1'b0, 1'b0, 4'd0);
        sam(32'd10, 1'b0, 1'b0, 1'b0, 4'd0);
        // 20 rise/fall cycles, counter saturates at 15
        ev = 0;
        for (int k = 0; k < 20; k++) begin
            for (int j = 0; j < 4; j++)
                sam(32'd120, j == 3, j == 3, 1'b0, 4'((j == 3 && ev < 15) ? ev + 1 : ev));
            if (ev < 15) ev++;
            for (int j = 0; j < 4; j++)
                sam(32'd10, j != 3, 1'b0, j == 3, 4'(ev));
        end
        // Clear coinciding with a rise gives 1; clear alone gives 0
        for (int i = 0; i < 3; i++) sam(32'd120, 1'b0, 1'b0, 1'b0, 4'd15);
        add(1'b1, 1'b1, 32'd120, 32'd100, 32'd50, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1);
        sam(32'd120, 1'b1, 1'b0, 1'b0, 4'd1);
        add(1'b1, 1'b0, 32'd0, 32'd100, 32'd50, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

        // Standalone reset-state check
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        din      = 32'd120;
        cnt_clr  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if ({cfg_err, level, rise_pulse, fall_pulse, event_count} !== 8'd0) begin
            errors++;
            $display("FAIL reset state {cfg_err,level,rise,fall,count}: got=%b exp=%b",
                     {cfg_err, level, rise_pulse, fall_pulse, event_count}, 8'd0);
        end

        foreach (tbl[i]) begin
            @(negedge clk);
            rst_n    = tbl[i].rst_n;
            in_valid = tbl[i].vld;
            din      = tbl[i].din;
            thr_hi   = tbl[i].hi;
            thr_lo   = tbl[i].lo;
            cnt_clr  = tbl[i].clr;
            exp_q.push_back(tbl[i].exp);
            @(posedge clk);
            #1;
            got = {cfg_err, level, rise_pulse, fall_pulse, event_count};
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL vec%0d {cfg_err,level,rise,fall,count}: got=%b exp=%b", i, got, e);
            end
        end
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
